// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner extraction path.
package harris_pkg;

    localparam int SCORE_W = 33;
    localparam int COORD_W = 10;
    localparam int NMS_WIN = 3;
    localparam int BORDER  = 1;

    typedef struct packed {
        logic        [COORD_W-1:0] x;
        logic        [COORD_W-1:0] y;
        logic signed [SCORE_W-1:0] score;
    } corner_t;

endpackage

// File: rtl/corner_fifo.sv
// First-word fall-through FIFO of corner records; head is visible whenever empty is low.
module corner_fifo
    import harris_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  corner_t push_data,
    input  logic    pop,
    output corner_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    corner_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/harris_corner_extractor.sv
// Thresholds a raster stream of Harris scores, applies 3x3 non-maximum suppression and
// queues (x, y, score) corner records for the downstream descriptor stage.
module harris_corner_extractor
    import harris_pkg::*;
#(
    parameter int SCORE_BITS     = SCORE_W,
    parameter int MAX_ROW_LENGTH = 640,
    parameter int COORD_BITS     = COORD_W,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic        [COORD_BITS-1:0] r_row_length,
    input  logic signed [SCORE_BITS-1:0] r_threshold,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [SCORE_BITS-1:0] in_score,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [COORD_BITS-1:0] out_x,
    output logic        [COORD_BITS-1:0] out_y,
    output logic signed [SCORE_BITS-1:0] out_score,
    output logic                         out_overflow
);

    logic        [COORD_BITS-1:0] x_q, y_q, cur_x, cur_y;
    logic signed [SCORE_BITS-1:0] lb0 [MAX_ROW_LENGTH];
    logic signed [SCORE_BITS-1:0] lb1 [MAX_ROW_LENGTH];
    logic signed [SCORE_BITS-1:0] win_q [0:2][0:1];
    logic signed [SCORE_BITS-1:0] col_top, col_mid, centre;
    logic                         last_col, is_cand, pass, push, pop, full, empty, drop;
    corner_t                      push_rec, head;

    assign cur_x    = in_sof ? '0 : x_q;
    assign cur_y    = in_sof ? '0 : y_q;
    assign last_col = (cur_x == r_row_length - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (in_valid) begin
            if (last_col) begin
                x_q <= '0;
                y_q <= (&cur_y) ? cur_y : cur_y + 1'b1;
            end else begin
                x_q <= cur_x + 1'b1;
                y_q <= cur_y;
            end
        end
    end

    // lb0 holds row y-1 and lb1 row y-2 at each column; no reset, the y gate masks stale data.
    assign col_top = lb1[cur_x];
    assign col_mid = lb0[cur_x];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[cur_x] <= col_mid;
            lb0[cur_x] <= in_score;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) win_q[r][0] <= win_q[r][1];
            win_q[0][1] <= col_top;
            win_q[1][1] <= col_mid;
            win_q[2][1] <= in_score;
        end
    end

    // Strict against earlier raster neighbours, non-strict against later ones:
    // a plateau reports only its first pixel.
    assign centre  = win_q[1][1];
    assign is_cand = (cur_x >= COORD_BITS'(NMS_WIN - 1)) && (cur_y >= COORD_BITS'(NMS_WIN - 1));
    assign pass    = (centre >  r_threshold) &&
                     (centre >  win_q[0][0]) && (centre >  win_q[0][1]) &&
                     (centre >  col_top)     && (centre >  win_q[1][0]) &&
                     (centre >= col_mid)     && (centre >= win_q[2][0]) &&
                     (centre >= win_q[2][1]) && (centre >= in_score);
    assign push    = in_valid && is_cand && pass;

    always_comb begin
        push_rec       = '0;
        push_rec.x     = cur_x - COORD_BITS'(BORDER);
        push_rec.y     = cur_y - COORD_BITS'(BORDER);
        push_rec.score = centre;
    end

    // Output handshake: a record transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops while a record is pending, and out_* stay stable until accepted.
    assign out_valid = !empty;
    assign pop       = out_ready && !empty;
    assign drop      = push && full && !pop;

    corner_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_x     = empty ? '0 : head.x;
    assign out_y     = empty ? '0 : head.y;
    assign out_score = empty ? '0 : head.score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    out_overflow <= 1'b0;
        else if (drop)                out_overflow <= 1'b1;
        else if (in_valid && in_sof)  out_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_harris_corner_extractor.sv
// Directed bench for harris_corner_extractor on an 8x6 frame with a 4-entry output FIFO.
module tb_harris_corner_extractor;

    localparam int SW   = 33;
    localparam int CW   = 10;
    localparam int RW   = 2 * CW + SW;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic        [CW-1:0] r_row_length;
    logic signed [SW-1:0] r_threshold;
    logic                 in_valid;
    logic                 in_sof;
    logic signed [SW-1:0] in_score;
    logic                 out_valid;
    logic                 out_ready;
    logic        [CW-1:0] out_x;
    logic        [CW-1:0] out_y;
    logic signed [SW-1:0] out_score;
    logic                 out_overflow;

    logic [RW-1:0]        exp_q[$];
    logic [RW-1:0]        mon_exp;
    logic signed [SW-1:0] pix [NPIX];
    int                   errors = 0;
    int                   checks = 0;

    harris_corner_extractor #(
        .SCORE_BITS     (SW),
        .MAX_ROW_LENGTH (640),
        .COORD_BITS     (CW),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .r_row_length (r_row_length),
        .r_threshold  (r_threshold),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_score     (in_score),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_score    (out_score),
        .out_overflow (out_overflow)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rec(input int x, input int y, input int s);
        logic signed [SW-1:0] sv;
        sv = SW'(s);
        return {CW'(x), CW'(y), sv};
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) pix[i] = '0;
    endtask

    task automatic put(input int x, input int y, input int v);
        pix[y * COLS + x] = SW'(v);
    endtask

    // ---------------- drivers ----------------
    task automatic beat(input logic signed [SW-1:0] s, input logic sof);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_score = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            beat(pix[i], (i == 0));
        end
    endtask

    task automatic finish_frame(input string tag);
        idle(20);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle_valid"}, out_valid, 1'b0);
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        send_range(0, NPIX - 1, gaps);
        finish_frame(tag);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
            else                   mon_exp = 'x;
            chk("record", {out_x, out_y, out_score}, mon_exp);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_score     = '0;
        out_ready    = 1'b1;
        r_row_length = CW'(COLS);
        r_threshold  = SW'(100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_overflow", out_overflow, 1'b0);
        chk("rst_x", out_x, '0);
        chk("rst_y", out_y, '0);
        chk("rst_score", out_score, '0);
        reset = 1'b0;

        // single peak with latency check around beat (4,3) = pixel 28
        clear_frame();
        put(3, 2, 500);
        exp_q.push_back(rec(3, 2, 500));
        send_range(0, 28, 1'b0);
        @(negedge clk);
        chk("lat_before", out_valid, 1'b0);
        send_range(29, 29, 1'b0);
        @(negedge clk);
        chk("lat_after", out_valid, 1'b1);
        send_range(30, NPIX - 1, 1'b0);
        finish_frame("peak");

        // threshold is strict
        clear_frame();
        put(3, 2, 100);
        run_frame("thr_eq", 1'b0);
        clear_frame();
        put(3, 2, 101);
        exp_q.push_back(rec(3, 2, 101));
        run_frame("thr_gt", 1'b0);

        // signed compare with a negative threshold
        r_threshold = -SW'(50);
        for (int i = 0; i < NPIX; i++) pix[i] = -SW'(100);
        put(3, 2, -20);
        exp_q.push_back(rec(3, 2, -20));
        run_frame("neg", 1'b0);
        r_threshold = SW'(100);

        // plateaus: first pixel in raster order wins
        clear_frame();
        put(2, 2, 300);
        put(3, 2, 300);
        exp_q.push_back(rec(2, 2, 300));
        run_frame("plat_h", 1'b0);
        clear_frame();
        put(2, 2, 300);
        put(2, 3, 300);
        exp_q.push_back(rec(2, 2, 300));
        run_frame("plat_v", 1'b0);

        // borders never report; (1,1) is the first reportable pixel
        clear_frame();
        put(0, 3, 900);
        put(7, 3, 900);
        put(3, 0, 900);
        put(3, ROWS - 1, 900);
        run_frame("border", 1'b0);
        clear_frame();
        put(1, 1, 900);
        exp_q.push_back(rec(1, 1, 900));
        run_frame("inner", 1'b0);

        // backpressure: 6 isolated peaks into a 4-deep FIFO
        out_ready = 1'b0;
        clear_frame();
        put(1, 1, 200); put(3, 1, 210); put(5, 1, 220);
        put(1, 3, 230); put(3, 3, 240); put(5, 3, 250);
        exp_q.push_back(rec(1, 1, 200));
        exp_q.push_back(rec(3, 1, 210));
        exp_q.push_back(rec(5, 1, 220));
        exp_q.push_back(rec(1, 3, 230));
        send_range(0, NPIX - 1, 1'b0);
        idle(3);
        chk("bp_overflow", out_overflow, 1'b1);
        chk("bp_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        finish_frame("bp");
        chk("bp_sticky", out_overflow, 1'b1);
        beat('0, 1'b1);
        idle(2);
        chk("bp_sof_clear", out_overflow, 1'b0);

        // full FIFO with push and pop together: (3,3) lands at beat (4,4) = pixel 36
        out_ready = 1'b0;
        clear_frame();
        put(1, 1, 200); put(3, 1, 210); put(5, 1, 220);
        put(1, 3, 230); put(3, 3, 240);
        exp_q.push_back(rec(1, 1, 200));
        exp_q.push_back(rec(3, 1, 210));
        exp_q.push_back(rec(5, 1, 220));
        exp_q.push_back(rec(1, 3, 230));
        exp_q.push_back(rec(3, 3, 240));
        send_range(0, 35, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sof    = 1'b0;
        in_score  = pix[36];
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_score  = pix[37];
        send_range(38, NPIX - 1, 1'b0);
        idle(2);
        chk("pp_no_drop", out_overflow, 1'b0);
        chk("pp_pending", exp_q.size(), 4);
        out_ready = 1'b1;
        finish_frame("pp");

        // asynchronous reset mid-frame while records are pending
        out_ready = 1'b0;
        clear_frame();
        put(1, 1, 200); put(3, 1, 210); put(5, 1, 220);
        put(1, 3, 230); put(3, 3, 240); put(5, 3, 250);
        send_range(0, 43, 1'b0);
        #2;
        chk("ar_pre_valid", out_valid, 1'b1);
        chk("ar_pre_overflow", out_overflow, 1'b1);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_overflow", out_overflow, 1'b0);
        chk("ar_score", out_score, '0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_frame();
        put(3, 2, 500);
        exp_q.push_back(rec(3, 2, 500));
        run_frame("ar_next", 1'b0);

        // in_valid gaps must not change the result
        clear_frame();
        put(1, 1, 200); put(3, 1, 210); put(5, 1, 220);
        put(1, 3, 230); put(3, 3, 240);
        exp_q.push_back(rec(1, 1, 200));
        exp_q.push_back(rec(3, 1, 210));
        exp_q.push_back(rec(5, 1, 220));
        exp_q.push_back(rec(1, 3, 230));
        exp_q.push_back(rec(3, 3, 240));
        run_frame("gap_peaks", 1'b1);
        clear_frame();
        put(2, 2, 300);
        put(3, 2, 300);
        exp_q.push_back(rec(2, 2, 300));
        run_frame("gap_plat", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
